// File: rtl/dpi_stream_feeder.sv
// Serialises ingress packet words into the per-byte matcher stream and drives
// stream_id / enable / new_stream_id from a per-flow table.
module dpi_stream_feeder #(
  parameter int unsigned SID_W   = 6,
  parameter int unsigned NUM_M   = 16,
  parameter int unsigned EOP_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [1:0]       in_nbytes,
  input  logic [SID_W-1:0] in_sid,
  input  logic             cfg_we,
  input  logic             cfg_clr,
  input  logic [SID_W-1:0] cfg_sid,
  input  logic [NUM_M-1:0] cfg_mask,
  output logic             load_state,
  output logic             new_stream_id,
  output logic [SID_W-1:0] stream_id,
  output logic [NUM_M-1:0] enable,
  output logic [7:0]       char_in,
  output logic             char_in_vld,
  output logic             eop,
  output logic [15:0]      pkt_cnt,
  output logic             proto_err
);

  localparam int unsigned NUM_FLOWS = 1 << SID_W;
  localparam int unsigned GAP_W     = (EOP_GAP > 1) ? $clog2(EOP_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_STREAM, S_DRAIN, S_EOP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic [1:0]          nb_q, nb_d;
  logic [1:0]          idx_q, idx_d;
  logic                have_q, have_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NUM_FLOWS-1:0] seen_q;
  logic [NUM_M-1:0]    mask_q [NUM_FLOWS];

  logic                acc_c, take_sop_c;
  logic                in_ready_d, load_d, new_d, vld_d, eop_d, perr_d;
  logic [SID_W-1:0]    sid_d;
  logic [NUM_M-1:0]    en_d;
  logic [7:0]          char_d;
  logic [15:0]         cnt_d;

  // Index of the last byte to emit from a held word.
  function automatic logic [1:0] final_idx(input logic last, input logic [1:0] nb);
    return last ? nb : 2'd3;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Next-state and next-output logic; outputs reflect the state being entered.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    nb_d       = nb_q;
    idx_d      = idx_q;
    have_d     = have_q;
    gap_d      = gap_q;
    load_d     = 1'b0;
    new_d      = 1'b0;
    sid_d      = stream_id;
    en_d       = enable;
    perr_d     = proto_err;
    take_sop_c = 1'b0;
    acc_c      = in_valid & in_ready;

    unique case (state_q)
      S_IDLE: begin
        if (acc_c && in_sop) begin
          state_d    = S_LOAD;
          word_d     = in_data;
          last_d     = in_eop;
          nb_d       = in_nbytes;
          load_d     = 1'b1;
          new_d      = ~seen_q[in_sid] | (cfg_clr & (cfg_sid == in_sid));
          sid_d      = in_sid;
          en_d       = mask_q[in_sid];
          take_sop_c = 1'b1;
        end
      end
      S_LOAD:  state_d = S_PRIME;
      S_PRIME: begin
        state_d = S_STREAM;
        idx_d   = 2'd0;
        have_d  = 1'b1;
      end
      S_STREAM: begin
        if (have_q && (idx_q != final_idx(last_q, nb_q))) begin
          idx_d = idx_q + 2'd1;
        end else if (have_q && last_q) begin
          have_d  = 1'b0;
          gap_d   = '0;
          state_d = (EOP_GAP == 0) ? S_EOP : S_DRAIN;
        end else if (acc_c) begin
          word_d = in_data;
          last_d = in_eop;
          nb_d   = in_nbytes;
          idx_d  = 2'd0;
          have_d = 1'b1;
          if (in_sop) perr_d = 1'b1;
        end else begin
          have_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (gap_q == GAP_W'(EOP_GAP - 1)) state_d = S_EOP;
        else gap_d = gap_q + 1'b1;
      end
      S_EOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    vld_d      = (state_d == S_STREAM) & have_d;
    char_d     = vld_d ? pick_byte(word_d, idx_d) : 8'd0;
    in_ready_d = (state_d == S_IDLE) |
                 ((state_d == S_STREAM) &
                  (~have_d | ((idx_d == final_idx(last_d, nb_d)) & ~last_d)));
    eop_d      = (state_d == S_EOP);
    cnt_d      = eop_d ? pkt_cnt + 16'd1 : pkt_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      last_q        <= 1'b0;
      nb_q          <= '0;
      idx_q         <= '0;
      have_q        <= 1'b0;
      gap_q         <= '0;
      in_ready      <= 1'b0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      enable        <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      pkt_cnt       <= '0;
      proto_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      last_q        <= last_d;
      nb_q          <= nb_d;
      idx_q         <= idx_d;
      have_q        <= have_d;
      gap_q         <= gap_d;
      in_ready      <= in_ready_d;
      load_state    <= load_d;
      new_stream_id <= new_d;
      stream_id     <= sid_d;
      enable        <= en_d;
      char_in       <= char_d;
      char_in_vld   <= vld_d;
      eop           <= eop_d;
      pkt_cnt       <= cnt_d;
      proto_err     <= perr_d;
    end
  end

  // Seen bitmap: a coincident retire and load of the same flow leaves it seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
    end else begin
      if (cfg_clr)    seen_q[cfg_sid] <= 1'b0;
      if (take_sop_c) seen_q[in_sid]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_FLOWS); i++) mask_q[i] <= '0;
    end else if (cfg_we) begin
      mask_q[cfg_sid] <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// Scoreboard bench for dpi_stream_feeder: a flow-table model predicts load,
// byte and eop events; a negedge monitor pops and compares them.
module tb_dpi_stream_feeder;
  localparam int unsigned SID_W   = 6;
  localparam int unsigned NUM_M   = 16;
  localparam int unsigned EOP_GAP = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_sop, in_eop;
  logic [31:0]      in_data;
  logic [1:0]       in_nbytes;
  logic [SID_W-1:0] in_sid, cfg_sid, stream_id;
  logic             cfg_we, cfg_clr;
  logic [NUM_M-1:0] cfg_mask, enable;
  logic             load_state, new_stream_id, char_in_vld, eop, proto_err;
  logic [7:0]       char_in;
  logic [15:0]      pkt_cnt;

  dpi_stream_feeder #(.SID_W(SID_W), .NUM_M(NUM_M), .EOP_GAP(EOP_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_nbytes(in_nbytes), .in_sid(in_sid),
    .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_sid(cfg_sid), .cfg_mask(cfg_mask),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .pkt_cnt(pkt_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SID_W-1:0] sid;
    logic             nw;
    logic [NUM_M-1:0] en;
    bit               contig;
  } load_t;

  load_t       exp_load[$];
  logic [7:0]  exp_chr[$];
  logic [15:0] exp_eop[$];

  bit          m_seen [64];
  logic [15:0] m_mask [64];
  logic [15:0] m_pkt;
  bit          m_perr;
  bit [31:0]   wq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_seen[i] = 1'b0;
      m_mask[i] = '0;
    end
    m_pkt  = '0;
    m_perr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) flag("in_ready_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_eop.size() != 0 || exp_chr.size() != 0 || exp_load.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg_pulse(input bit we, input bit clr, input logic [SID_W-1:0] sid,
                           input logic [NUM_M-1:0] mask);
    cfg_we = we; cfg_clr = clr; cfg_sid = sid; cfg_mask = mask;
    @(negedge clk);
    cfg_we = 1'b0; cfg_clr = 1'b0;
    if (we)  m_mask[sid] = mask;
    if (clr) m_seen[sid] = 1'b0;
  endtask

  // Push expected events for the packet in wq, then drive it word by word.
  task automatic send_pkt(input logic [SID_W-1:0] sid, input logic [1:0] last_nb,
                          input bit gaps, input bit sop_mid, input bit cfg_mid,
                          input logic [NUM_M-1:0] mid_mask);
    load_t L;
    int nw = wq.size();
    L.sid = sid; L.nw = !m_seen[sid]; L.en = m_mask[sid]; L.contig = !gaps;
    m_seen[sid] = 1'b1;
    exp_load.push_back(L);
    for (int i = 0; i < nw; i++) begin
      int nb = (i == nw - 1) ? int'(last_nb) + 1 : 4;
      for (int k = 0; k < nb; k++) exp_chr.push_back(8'(wq[i] >> (8 * (3 - k))));
    end
    m_pkt = m_pkt + 16'd1;
    exp_eop.push_back(m_pkt);
    if (sop_mid && nw > 1) m_perr = 1'b1;

    for (int i = 0; i < nw; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid  = 1'b1;
      in_data   = wq[i];
      in_sop    = (i == 0) || (sop_mid && i == 1);
      in_eop    = (i == nw - 1);
      in_nbytes = (i == nw - 1) ? last_nb : 2'($urandom);
      in_sid    = (i == 0) ? sid : SID_W'($urandom);
      wait_ready();
      @(negedge clk);
      if (i == 0 && cfg_mid) begin
        in_valid = 1'b0;
        cfg_pulse(1'b1, 1'b0, sid, mid_mask);
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  initial begin : monitor
    load_t cur;
    int load_cyc, first_cyc, last_cyc, nchr;
    logic [7:0] c;
    logic [15:0] e;
    cur = '{default: '0};
    load_cyc = 0; first_cyc = 0; last_cyc = 0; nchr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nchr = 0;
        continue;
      end
      if (load_state) begin
        if (exp_load.size() == 0) flag("spurious_load_state");
        else begin
          cur = exp_load.pop_front();
          check("load_stream_id", 64'(stream_id), 64'(cur.sid));
          check("new_stream_id", 64'(new_stream_id), 64'(cur.nw));
          check("load_enable", 64'(enable), 64'(cur.en));
          load_cyc = cyc;
          nchr = 0;
        end
      end
      if (char_in_vld) begin
        if (exp_chr.size() == 0) flag("spurious_char_in_vld");
        else begin
          c = exp_chr.pop_front();
          check("char_in", 64'(char_in), 64'(c));
        end
        if (nchr == 0) begin
          first_cyc = cyc;
          check("first_char_latency", 64'(cyc - load_cyc), 64'd2);
        end
        check("held_enable", 64'(enable), 64'(cur.en));
        last_cyc = cyc;
        nchr++;
      end
      if (eop) begin
        if (exp_eop.size() == 0) flag("spurious_eop");
        else begin
          e = exp_eop.pop_front();
          check("pkt_cnt", 64'(pkt_cnt), 64'(e));
          check("eop_stream_id", 64'(stream_id), 64'(cur.sid));
          check("eop_enable", 64'(enable), 64'(cur.en));
          check("eop_gap", 64'(cyc - last_cyc), 64'(EOP_GAP + 1));
          if (cur.contig) check("no_bubble", 64'(last_cyc - first_cyc + 1), 64'(nchr));
        end
        nchr = 0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [SID_W-1:0] rs;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_nbytes = '0; in_sid = '0;
    cfg_we = 1'b0; cfg_clr = 1'b0; cfg_sid = '0; cfg_mask = '0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 64'({in_ready, load_state, new_stream_id, stream_id, enable,
                                   char_in, char_in_vld, eop, pkt_cnt, proto_err}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Fresh flow, single word of four bytes.
    wq = '{32'h41424344};
    send_pkt(6'd5, 2'd3, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    check("pkt_cnt_first", 64'(pkt_cnt), 64'd1);

    // Same flow again, then retired and reused.
    wq = '{32'hDEADBEEF};
    send_pkt(6'd5, 2'd1, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    cfg_pulse(1'b0, 1'b1, 6'd5, '0);
    wq = '{32'h01020304};
    send_pkt(6'd5, 2'd0, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();

    // Word without sop while idle is dropped.
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 32'hCAFEF00D; in_sid = 6'd3;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0; in_eop = 1'b0;
    repeat (6) @(negedge clk);
    check("discard_pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));

    // Three words back to back, 10 bytes total.
    wq = '{32'h10111213, 32'h20212223, 32'h30313233};
    send_pkt(6'd9, 2'd1, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();

    // Mask written mid-packet applies from the next packet.
    wq = '{32'hA0A1A2A3, 32'hB0B1B2B3};
    send_pkt(6'd5, 2'd3, 1'b0, 1'b0, 1'b1, 16'h0003);
    wait_idle();
    wq = '{32'h55667788};
    send_pkt(6'd5, 2'd2, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();

    // sop on the second word flags a protocol error but the packet completes.
    check("proto_err_clear", 64'(proto_err), 64'(m_perr));
    wq = '{32'h11223344, 32'h55667788};
    send_pkt(6'd12, 2'd3, 1'b0, 1'b1, 1'b0, '0);
    wait_idle();
    check("proto_err_set", 64'(proto_err), 64'(m_perr));

    // Randomised packets with interleaved configuration traffic.
    for (int p = 0; p < 30; p++) begin
      int nw = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back($urandom);
      rs = SID_W'($urandom_range(0, 7));
      send_pkt(rs, 2'($urandom), 1'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0),
               NUM_M'($urandom));
      if ($urandom_range(0, 2) == 0)
        cfg_pulse(1'($urandom), 1'($urandom), SID_W'($urandom_range(0, 7)), NUM_M'($urandom));
    end
    wait_idle();
    check("pkt_cnt_random", 64'(pkt_cnt), 64'(m_pkt));

    // Reset while streaming: outputs drop at once, flow state forgotten.
    wq = '{32'h99AABBCC, 32'hDDEEFF00};
    begin
      load_t L;
      L.sid = 6'd5; L.nw = !m_seen[5]; L.en = m_mask[5]; L.contig = 1'b1;
      exp_load.push_back(L);
      for (int k = 0; k < 4; k++) exp_chr.push_back(8'(wq[0] >> (8 * (3 - k))));
    end
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = wq[0]; in_sid = 6'd5;
    wait_ready();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_mid_outputs", 64'({in_ready, load_state, new_stream_id, stream_id, enable,
                                       char_in, char_in_vld, eop, pkt_cnt, proto_err}), 64'd0);
    exp_load.delete(); exp_chr.delete(); exp_eop.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    repeat (4) @(negedge clk);
    check("no_eop_after_reset", 64'(pkt_cnt), 64'd0);
    wq = '{32'h61626364};
    send_pkt(6'd5, 2'd3, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    check("pkt_cnt_after_reset", 64'(pkt_cnt), 64'(m_pkt));
    check("idle_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
